// File: rtl/q2_lcd_writer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : q2_lcd_writer_if                                            |
// | Purpose  : Bundles the byte-input handshake and the LCD write-bus      |
// |            signals of q2_lcd_writer.                                   |
// | Signals  : in_valid/in_data/in_ready - byte stream from the CPU side   |
// |            lcd_wr/lcd_dbus           - strobed 12-bit LCD bus word     |
// |            cur_row/cur_col           - committed cursor position       |
// | Modports : master - byte source / bus observer                         |
// |            slave  - the writer itself                                  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface q2_lcd_writer_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        lcd_wr;
  logic [11:0] lcd_dbus;
  logic        cur_row;
  logic [3:0]  cur_col;

  modport master (
    output in_valid, in_data,
    input  in_ready, lcd_wr, lcd_dbus, cur_row, cur_col
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, lcd_wr, lcd_dbus, cur_row, cur_col
  );
endinterface
`default_nettype wire

// File: rtl/q2_lcd_writer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : q2_lcd_writer                                               |
// | Purpose  : Turns a byte stream into strobed write words for a 2x16     |
// |            character LCD (row 0 at 0x00, row 1 at 0x40). Tracks the    |
// |            cursor, wraps lines, decodes FF/LF/CR and clears the        |
// |            display after reset.                                        |
// | Ports    : clk   - system clock, rising edge                           |
// |            rst_n - asynchronous active-low reset                       |
// |            bus   - q2_lcd_writer_if.slave (byte input, LCD bus,        |
// |                    cursor outputs)                                     |
// | Params   : SETUP/PULSE/HOLD - bus phase lengths in cycles (min 1)      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module q2_lcd_writer #(
  parameter int SETUP = 2,
  parameter int PULSE = 2,
  parameter int HOLD  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  q2_lcd_writer_if.slave    bus
);

  localparam int MAXC  = (SETUP > PULSE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                         : ((PULSE > HOLD) ? PULSE : HOLD);
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;

  localparam logic [11:0] WORD_CLEAR = 12'h101;

  logic [2:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [11:0]      dbus_q,      dbus_d;
  logic             wr_q,        wr_d;
  logic             ready_q,     ready_d;
  logic             wrap_pend_q, wrap_pend_d;
  logic [11:0]      wrap_word_q, wrap_word_d;
  logic             row_q,       row_d;
  logic [3:0]       col_q,       col_d;
  // Cursor position to commit once the current transaction finishes.
  logic             nrow_q,      nrow_d;
  logic [3:0]       ncol_q,      ncol_d;

  logic [11:0]      w_set_other;
  logic [11:0]      w_set_this;

  // Set-address words for the start of the other row and of the current row.
  assign w_set_other = {3'b000, 1'b1, 1'b1, ~row_q, 6'b000000};
  assign w_set_this  = {3'b000, 1'b1, 1'b1,  row_q, 6'b000000};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dbus_d      = dbus_q;
    wrap_pend_d = wrap_pend_q;
    wrap_word_d = wrap_word_q;
    row_d       = row_q;
    col_d       = col_q;
    nrow_d      = nrow_q;
    ncol_d      = ncol_q;

    case (state_q)
      ST_INIT: begin
        dbus_d      = WORD_CLEAR;
        nrow_d      = 1'b0;
        ncol_d      = 4'd0;
        wrap_pend_d = 1'b0;
        cnt_d       = '0;
        state_d     = ST_SETUP;
      end
      ST_IDLE: begin
        if (bus.in_valid) begin
          cnt_d       = '0;
          wrap_pend_d = 1'b0;
          state_d     = ST_SETUP;
          case (bus.in_data)
            8'h0C: begin
              dbus_d = WORD_CLEAR;
              nrow_d = 1'b0;
              ncol_d = 4'd0;
            end
            8'h0A: begin
              dbus_d = w_set_other;
              nrow_d = ~row_q;
              ncol_d = 4'd0;
            end
            8'h0D: begin
              dbus_d = w_set_this;
              nrow_d = row_q;
              ncol_d = 4'd0;
            end
            default: begin
              dbus_d = {4'b0000, bus.in_data};
              if (col_q == 4'd15) begin
                // Last column: the display would run past the row, so a
                // re-address to the other row follows in the same transaction.
                wrap_pend_d = 1'b1;
                wrap_word_d = w_set_other;
                nrow_d      = ~row_q;
                ncol_d      = 4'd0;
              end else begin
                nrow_d = row_q;
                ncol_d = col_q + 4'd1;
              end
            end
          endcase
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(SETUP - 1)) begin
          cnt_d   = '0;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == CNT_W'(PULSE - 1)) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD - 1)) begin
          cnt_d   = '0;
          state_d = ST_NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_NEXT: begin
        if (wrap_pend_q) begin
          dbus_d      = wrap_word_q;
          wrap_pend_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_SETUP;
        end else begin
          row_d   = nrow_q;
          col_d   = ncol_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Strobe and ready are registered decodes of the next state so the
    // pins never glitch on state-register transitions.
    wr_d    = (state_d == ST_STROBE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      dbus_q      <= 12'h000;
      wr_q        <= 1'b0;
      ready_q     <= 1'b0;
      wrap_pend_q <= 1'b0;
      wrap_word_q <= 12'h000;
      row_q       <= 1'b0;
      col_q       <= 4'd0;
      nrow_q      <= 1'b0;
      ncol_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dbus_q      <= dbus_d;
      wr_q        <= wr_d;
      ready_q     <= ready_d;
      wrap_pend_q <= wrap_pend_d;
      wrap_word_q <= wrap_word_d;
      row_q       <= row_d;
      col_q       <= col_d;
      nrow_q      <= nrow_d;
      ncol_q      <= ncol_d;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.lcd_wr   = wr_q;
  assign bus.lcd_dbus = dbus_q;
  assign bus.cur_row  = row_q;
  assign bus.cur_col  = col_q;

endmodule
`default_nettype wire

// File: tb/tb_q2_lcd_writer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_q2_lcd_writer                                            |
// | Purpose  : Self-checking bench for q2_lcd_writer: directed timing      |
// |            cases plus random byte streams against a cursor/word model. |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_q2_lcd_writer;

  localparam int SETUP = 2;
  localparam int PULSE = 2;
  localparam int HOLD  = 1;
  localparam int T     = SETUP + PULSE + HOLD;

  logic clk;
  logic rst_n;

  q2_lcd_writer_if bus ();

  q2_lcd_writer #(.SETUP(SETUP), .PULSE(PULSE), .HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: display-level view of cursor and expected bus words.
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  int m_row = 0;
  int m_col = 0;

  task automatic model_byte(input logic [7:0] b, output int lat);
    lat = T + 1;
    if (b == 8'h0C) begin
      exp_q.push_back(12'h101);
      m_row = 0; m_col = 0;
    end else if (b == 8'h0A) begin
      m_row = 1 - m_row;
      exp_q.push_back(12'(12'h180 + m_row * 64));
      m_col = 0;
    end else if (b == 8'h0D) begin
      exp_q.push_back(12'(12'h180 + m_row * 64));
      m_col = 0;
    end else begin
      exp_q.push_back({4'h0, b});
      if (m_col == 15) begin
        m_row = 1 - m_row;
        m_col = 0;
        exp_q.push_back(12'(12'h180 + m_row * 64));
        lat = 2 * (T + 1);
      end else begin
        m_col = m_col + 1;
      end
    end
  endtask

  // Bus monitor: captures each strobed word and checks strobe timing.
  logic        prev_wr;
  logic [11:0] prev_dbus;
  int          stable_cnt;
  int          hi_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr = 1'b0; prev_dbus = 12'h000; stable_cnt = 0; hi_cnt = 0;
    end else begin
      if (bus.lcd_dbus != prev_dbus) stable_cnt = 0;
      else stable_cnt++;
      if (bus.lcd_wr && !prev_wr) begin
        obs_q.push_back(bus.lcd_dbus);
        check("setup_time", 32'(stable_cnt >= SETUP), 1);
        hi_cnt = 0;
      end
      if (bus.lcd_wr) hi_cnt++;
      if (!bus.lcd_wr && prev_wr) check("pulse_width", hi_cnt, PULSE);
      prev_wr   = bus.lcd_wr;
      prev_dbus = bus.lcd_dbus;
    end
  end

  // Counts rising edges until in_ready is seen (sampled 1 unit after the edge).
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic compare_words();
    check("nwords", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check("word", obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_cursor();
    check("cur_row", bus.cur_row, m_row);
    check("cur_col", bus.cur_col, m_col);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n, lat, exp_lat;
    wait_ready(n);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    model_byte(b, exp_lat);
    wait_ready(lat);
    check("latency", lat, exp_lat);
    compare_words();
    check_cursor();
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n, lat;
    logic [7:0] b;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #13;
    check("rst_wr", bus.lcd_wr, 0);
    check("rst_dbus", bus.lcd_dbus, 0);
    check("rst_ready", bus.in_ready, 0);
    check_cursor();

    // Power-up clear: IDLE on the 7th edge after release (INIT occupies the
    // cycle in which release happens).
    do_reset();
    exp_q.push_back(12'h101);
    wait_ready(n);
    check("pwr_ready_edges", n, 7);
    compare_words();
    check_cursor();

    // Single data write with cycle-exact timing.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model_byte(8'h41, lat);
    for (int k = 0; k <= 6; k++) begin
      if (k <= 4) check("w41_dbus", bus.lcd_dbus, 12'h041);
      check("w41_wr", bus.lcd_wr, (k == 2 || k == 3) ? 1 : 0);
      check("w41_ready", bus.in_ready, (k == 6) ? 1 : 0);
      if (k < 6) begin @(posedge clk); #1; end
    end
    compare_words();
    check_cursor();

    // Full row from (0,0) with wrap to row 1.
    send_byte(8'h0C);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h30 + i));

    // Control codes.
    for (int i = 0; i < 5; i++) send_byte(8'h61);
    send_byte(8'h0A);
    for (int i = 0; i < 3; i++) send_byte(8'h62);
    send_byte(8'h0D);
    send_byte(8'h0C);

    // Byte held valid through the busy period: consumed exactly once.
    wait_ready(n);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h42;
    @(posedge clk); #1;
    for (int k = 1; k <= 3; k++) begin @(posedge clk); #1; end
    bus.in_data = 8'h55;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_busy_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    model_byte(8'h42, lat);
    wait_ready(n);
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
    compare_words();
    check_cursor();

    // Random stream.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'h0A;
        1: b = 8'h0D;
        2: b = ($urandom_range(0, 3) == 0) ? 8'h0C : 8'h7A;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_byte(b);
    end

    // Reset during STROBE of a wrapping data word.
    send_byte(8'h0D);
    for (int i = 0; i < 15; i++) send_byte(8'h43);
    check("pre_wrap_col", bus.cur_col, 15);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h58;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_wr_high", bus.lcd_wr, 1);
    rst_n = 1'b0;
    #1;
    check("abort_wr", bus.lcd_wr, 0);
    check("abort_dbus", bus.lcd_dbus, 0);
    check("abort_ready", bus.in_ready, 0);
    obs_q.delete();
    exp_q.delete();
    m_row = 0; m_col = 0;
    check_cursor();
    do_reset();
    exp_q.push_back(12'h101);
    wait_ready(n);
    check("rerst_ready_edges", n, 7);
    for (int k = 0; k < 20; k++) begin @(posedge clk); #1; end
    compare_words();
    check_cursor();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
